// File: rtl/tp84_snd_mixer.sv
// Sound mixer: time-multiplexed MAC of up to four unsigned channels with per-channel
// Q2.6 gain, x4 scaling and 16-bit saturation, emitted once per DIV-cycle tick.
module tp84_snd_mixer #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned DIV  = 220,
  parameter int unsigned IN_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_W-1:0]     ch0,
  input  logic [IN_W-1:0]     ch1,
  input  logic [IN_W-1:0]     ch2,
  input  logic [IN_W-1:0]     ch3,
  input  logic [7:0]          gain0,
  input  logic [7:0]          gain1,
  input  logic [7:0]          gain2,
  input  logic [7:0]          gain3,
  input  logic                mute,
  output logic signed [15:0]  out,
  output logic                out_valid
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW    = IN_W + 1;
  localparam int unsigned GW    = 9;
  localparam int unsigned PW    = SW + GW;
  localparam int unsigned ACC_W = PW + 2;
  localparam int unsigned SC_W  = ACC_W + 2;
  localparam int unsigned MID   = 1 << (IN_W - 1);

  localparam logic signed [SC_W-1:0] SAT_MAX = SC_W'(32767);
  localparam logic signed [SC_W-1:0] SAT_MIN = SC_W'(-32768);

  typedef enum logic [2:0] {
    S_IDLE, S_SNAP, S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_SAT, S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]        cnt;
  logic                    tick_c;
  logic [IN_W-1:0]         sh_ch   [4];
  logic [7:0]              sh_gain [4];
  logic                    sh_mute;
  logic signed [ACC_W-1:0] acc;
  logic [1:0]              sel_c;
  logic                    mac_en_c;
  logic signed [SW-1:0]    s_c;
  logic signed [GW-1:0]    g_c;
  logic signed [PW-1:0]    prod_c;
  logic signed [SC_W-1:0]  scaled_c;
  logic signed [15:0]      sat_c;

  // Free-running sample-rate divider, independent of the sequencer.
  assign tick_c = (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)       cnt <= '0;
    else if (tick_c) cnt <= '0;
    else             cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Sequencer; a tick seen outside IDLE is ignored.
  always_comb begin
    state_nxt = state;
    sel_c     = 2'd0;
    mac_en_c  = 1'b0;
    case (state)
      S_IDLE: if (tick_c) state_nxt = S_SNAP;
      S_SNAP: state_nxt = S_MAC0;
      S_MAC0: begin
        sel_c    = 2'd0;
        mac_en_c = 1'b1;
        if (NCH > 1) state_nxt = S_MAC1;
        else         state_nxt = S_SAT;
      end
      S_MAC1: begin
        sel_c    = 2'd1;
        mac_en_c = 1'b1;
        if (NCH > 2) state_nxt = S_MAC2;
        else         state_nxt = S_SAT;
      end
      S_MAC2: begin
        sel_c    = 2'd2;
        mac_en_c = 1'b1;
        if (NCH > 3) state_nxt = S_MAC3;
        else         state_nxt = S_SAT;
      end
      S_MAC3: begin
        sel_c     = 2'd3;
        mac_en_c  = 1'b1;
        state_nxt = S_SAT;
      end
      S_SAT:   state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Inputs are only observed in SNAP so the sample in flight is self-consistent.
  always_ff @(posedge clk) begin
    if (state == S_SNAP) begin
      sh_ch[0]   <= ch0;
      sh_ch[1]   <= ch1;
      sh_ch[2]   <= ch2;
      sh_ch[3]   <= ch3;
      sh_gain[0] <= gain0;
      sh_gain[1] <= gain1;
      sh_gain[2] <= gain2;
      sh_gain[3] <= gain3;
      sh_mute    <= mute;
    end
  end

  assign s_c    = SW'(sh_ch[sel_c]) - SW'(MID);
  assign g_c    = {1'b0, sh_gain[sel_c]};
  assign prod_c = PW'(s_c) * PW'(g_c);

  always_ff @(posedge clk) begin
    if (reset)                 acc <= '0;
    else if (state == S_SNAP)  acc <= '0;
    else if (mac_en_c)         acc <= acc + ACC_W'(prod_c);
  end

  assign scaled_c = {acc, 2'b00};

  always_comb begin
    if (scaled_c > SAT_MAX)      sat_c = 16'sh7FFF;
    else if (scaled_c < SAT_MIN) sat_c = 16'sh8000;
    else                         sat_c = scaled_c[15:0];
  end

  // Result lands at the end of SAT so out_valid is high for the OUT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == S_SAT);
      if (state == S_SAT) out <= sh_mute ? 16'sd0 : sat_c;
    end
  end

endmodule

// File: tb/tb_tp84_snd_mixer.sv
// Directed bench for tp84_snd_mixer: timing, arithmetic table, snapshot, reset abort.
module tb_tp84_snd_mixer;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        tch [4];
  logic [7:0]        tg  [4];
  logic              mute;
  logic signed [15:0] out;
  logic              out_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tp84_snd_mixer #(.NCH(4), .DIV(220), .IN_W(8)) dut (
    .clk(clk), .reset(reset),
    .ch0(tch[0]), .ch1(tch[1]), .ch2(tch[2]), .ch3(tch[3]),
    .gain0(tg[0]), .gain1(tg[1]), .gain2(tg[2]), .gain3(tg[3]),
    .mute(mute), .out(out), .out_valid(out_valid)
  );

  typedef struct {
    string           name;
    logic [3:0][7:0] ch;
    logic [3:0][7:0] g;
    logic            mute;
    int              exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string name, int c0, int c1, int c2, int c3,
                              int g0, int g1, int g2, int g3, int m, int exp);
    vec_t r;
    r.name = name;
    r.ch[0] = 8'(c0); r.ch[1] = 8'(c1); r.ch[2] = 8'(c2); r.ch[3] = 8'(c3);
    r.g[0]  = 8'(g0); r.g[1]  = 8'(g1); r.g[2]  = 8'(g2); r.g[3]  = 8'(g3);
    r.mute = 1'(m);
    r.exp  = exp;
    return r;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(vec_t v);
    for (int k = 0; k < 4; k++) begin
      tch[k] = v.ch[k];
      tg[k]  = v.g[k];
    end
    mute = v.mute;
  endtask

  // Returns edges elapsed until out_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 600);
    if (!out_valid) check("valid_timeout", 0, 1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    mute  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tch[k] = 8'd128;
      tg[k]  = 8'd64;
    end

    // Arithmetic table (inputs applied right after the previous sample)
    vq.push_back(mk("unity_pos",   255,128,128,128,  64, 64, 64, 64, 0,  32512));
    vq.push_back(mk("unity_neg",     0,128,128,128,  64, 64, 64, 64, 0, -32768));
    vq.push_back(mk("lsb_pos",     129,128,128,128,   1, 64, 64, 64, 0,      4));
    vq.push_back(mk("lsb_neg",     127,128,128,128,   1, 64, 64, 64, 0,     -4));
    vq.push_back(mk("sat_pos",     255,255,255,255, 255,255,255,255, 0,  32767));
    vq.push_back(mk("sat_neg",       0,  0,  0,  0, 255,255,255,255, 0, -32768));
    vq.push_back(mk("mixed",       255,  0,128,128, 255,255,255,255, 0,  -1020));
    vq.push_back(mk("mute",        255,128,128,128,  64, 64, 64, 64, 1,      0));
    vq.push_back(mk("gain_off",    255,128,128,128,   0, 64, 64, 64, 0,      0));
    vq.push_back(mk("ch1_only",    128,130,128,128,  64,200, 64, 64, 0,   1600));
    vq.push_back(mk("ch2_only",    128,128, 64,128,  64, 64, 32, 64, 0,  -8192));
    vq.push_back(mk("ch3_clip",    128,128,128,192,  64, 64, 64,128, 0,  32767));

    repeat (3) @(posedge clk);
    #1;
    check("rst_out", int'(out), 0);
    check("rst_valid", int'(out_valid), 0);
    reset = 1'b0;

    // Edge e is the (e+1)-th posedge with reset low
    for (int e = 0; e < 670; e++) begin
      @(posedge clk); #1;
      check("tick", int'(dut.tick_c), ((e % 220) == 218) ? 1 : 0);
      check("valid_timing", int'(out_valid), (e == 225 || e == 445 || e == 665) ? 1 : 0);
      check("silence", int'(out), 0);
    end

    foreach (vq[i]) begin
      apply(vq[i]);
      wait_valid(n);
      check(vq[i].name, int'(out), vq[i].exp);
      @(posedge clk); #1;
      check("pulse_width", int'(out_valid), 0);
      check("hold", int'(out), vq[i].exp);
    end

    // Snapshot isolation: ch0 changes right after the SNAP capture edge
    apply(mk("snap_a", 200,128,128,128, 64,64,64,64, 0, 18432));
    wait_valid(n);
    check("snap_pre", int'(out), 18432);
    repeat (215) @(posedge clk);
    #1;
    tch[0] = 8'd50;
    wait_valid(n);
    check("snap_latency", n, 5);
    check("snap_held", int'(out), 18432);
    wait_valid(n);
    check("snap_period", n, 220);
    check("snap_next", int'(out), -19968);

    // Reset pulse during MAC_2 aborts the sample
    tch[0] = 8'd255;
    repeat (217) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_out", int'(out), 0);
    check("abort_valid", int'(out_valid), 0);
    wait_valid(n);
    check("abort_latency", n, 226);
    check("abort_next", int'(out), 32512);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
